// File: rtl/i2c_target_phy.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : i2c_target_phy
// Brief    : I2C target bit/byte engine: synchronizer, glitch filter, START/STOP
//            detection, address match, write/read byte transfer, clock stretch.
// Revision : 1.0 - initial release
//==============================================================================
module i2c_target_phy #(
   parameter int FILTER_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_o,
   output logic       scl_t,
   output logic       sda_o,
   output logic       sda_t,
   input  logic [6:0] own_addr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       start_det,
   output logic       stop_det,
   output logic       addr_match,
   output logic       rw,
   output logic       busy
);

   localparam int c_CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_ADDR     = 4'd1,
      S_ADDR_ACK = 4'd2,
      S_RX_BYTE  = 4'd3,
      S_RX_ACK   = 4'd4,
      S_TX_LOAD  = 4'd5,
      S_TX_BYTE  = 4'd6,
      S_TX_ACK   = 4'd7,
      S_IGNORE   = 4'd8
   } state_t;

   // Index 0 carries SCL, index 1 carries SDA.
   logic [1:0]         w_raw;
   logic [1:0]         r_sync1;
   logic [1:0]         r_sync2;
   logic [1:0]         r_filt;
   logic [1:0]         r_filt_d;
   logic [c_CNT_W-1:0] r_fcnt [2];

   state_t             r_state;
   logic [7:0]         r_shift;
   logic [2:0]         r_bit_cnt;
   logic               r_byte_done;
   logic               r_ack;

   logic w_scl_f;
   logic w_sda_f;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;
   logic w_bit_state;

   assign w_raw       = {sda_i, scl_i};
   assign w_scl_f     = r_filt[0];
   assign w_sda_f     = r_filt[1];
   assign w_scl_rise  =  w_scl_f & ~r_filt_d[0];
   assign w_scl_fall  = ~w_scl_f &  r_filt_d[0];
   assign w_start     =  w_scl_f & ~w_sda_f &  r_filt_d[1];
   assign w_stop      =  w_scl_f &  w_sda_f & ~r_filt_d[1];
   assign w_bit_state = (r_state == S_ADDR) || (r_state == S_RX_BYTE) || (r_state == S_TX_BYTE);

   assign scl_t = scl_o;
   assign sda_t = sda_o;

   // The filtered level only moves after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 2'b11;
         r_sync2  <= 2'b11;
         r_filt   <= 2'b11;
         r_filt_d <= 2'b11;
         for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
      end else begin
         r_sync1  <= w_raw;
         r_sync2  <= r_sync1;
         r_filt_d <= r_filt;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == c_CNT_W'(FILTER_LEN - 1)) begin
               r_filt[i] <= r_sync2[i];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + c_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_shift     <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_byte_done <= 1'b0;
         r_ack       <= 1'b1;
         scl_o       <= 1'b1;
         sda_o       <= 1'b1;
         rx_data     <= 8'h00;
         rx_valid    <= 1'b0;
         tx_ready    <= 1'b0;
         start_det   <= 1'b0;
         stop_det    <= 1'b0;
         addr_match  <= 1'b0;
         rw          <= 1'b0;
         busy        <= 1'b0;
      end else begin
         start_det  <= w_start;
         stop_det   <= w_stop;
         rx_valid   <= 1'b0;
         addr_match <= 1'b0;
         if (w_stop) begin
            r_state     <= S_IDLE;
            sda_o       <= 1'b1;
            scl_o       <= 1'b1;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
         end else if (w_start) begin
            r_state     <= S_ADDR;
            sda_o       <= 1'b1;
            scl_o       <= 1'b1;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_byte_done <= 1'b0;
         end else begin
            // The counter wraps to 0 on the 8th rising edge and flags the byte.
            if (w_scl_rise && w_bit_state) begin
               r_bit_cnt <= r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
            end
            case (r_state)
               S_ADDR: begin
                  if (w_scl_rise) r_shift <= {r_shift[6:0], w_sda_f};
                  if (w_scl_fall && r_byte_done) begin
                     r_byte_done <= 1'b0;
                     if (r_shift[7:1] == own_addr) begin
                        rw         <= r_shift[0];
                        addr_match <= 1'b1;
                        sda_o      <= 1'b0;
                        r_state    <= S_ADDR_ACK;
                     end else begin
                        r_state    <= S_IGNORE;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     sda_o <= 1'b1;
                     if (rw) begin
                        tx_ready <= 1'b1;
                        r_state  <= S_TX_LOAD;
                     end else begin
                        r_state  <= S_RX_BYTE;
                     end
                  end
               end
               S_RX_BYTE: begin
                  if (w_scl_rise) begin
                     r_shift <= {r_shift[6:0], w_sda_f};
                     if (r_bit_cnt == 3'd7) begin
                        rx_data  <= {r_shift[6:0], w_sda_f};
                        rx_valid <= 1'b1;
                     end
                  end
                  if (w_scl_fall && r_byte_done) begin
                     r_byte_done <= 1'b0;
                     sda_o       <= 1'b0;
                     r_state     <= S_RX_ACK;
                  end
               end
               S_RX_ACK: begin
                  if (w_scl_fall) begin
                     sda_o   <= 1'b1;
                     r_state <= S_RX_BYTE;
                  end
               end
               S_TX_LOAD: begin
                  if (tx_valid && tx_ready) begin
                     r_shift  <= tx_data;
                     sda_o    <= tx_data[7];
                     scl_o    <= 1'b1;
                     tx_ready <= 1'b0;
                     r_state  <= S_TX_BYTE;
                  end else begin
                     scl_o    <= 1'b0;
                  end
               end
               S_TX_BYTE: begin
                  if (w_scl_fall) begin
                     if (r_byte_done) begin
                        r_byte_done <= 1'b0;
                        sda_o       <= 1'b1;
                        r_state     <= S_TX_ACK;
                     end else begin
                        sda_o   <= r_shift[6];
                        r_shift <= {r_shift[6:0], 1'b0};
                     end
                  end
               end
               S_TX_ACK: begin
                  if (w_scl_rise) r_ack <= w_sda_f;
                  if (w_scl_fall) begin
                     if (!r_ack) begin
                        tx_ready <= 1'b1;
                        r_state  <= S_TX_LOAD;
                     end else begin
                        r_state  <= S_IGNORE;
                     end
                  end
               end
               default: begin
                  sda_o <= 1'b1;
                  scl_o <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_phy.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_i2c_target_phy
// Brief    : Self-checking bench: bit-level I2C controller model plus scoreboards.
// Revision : 1.0 - initial release
//==============================================================================
module tb_i2c_target_phy;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_ctl, sda_ctl;
   logic       scl_bus, sda_bus;
   logic       scl_o, scl_t, sda_o, sda_t;
   logic [6:0] own_addr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       start_det, stop_det, addr_match, rw, busy;

   always #5 clk = ~clk;

   assign scl_bus = scl_ctl & scl_o;
   assign sda_bus = sda_ctl & sda_o;

   i2c_target_phy #(.FILTER_LEN(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_bus),
      .sda_i      (sda_bus),
      .scl_o      (scl_o),
      .scl_t      (scl_t),
      .sda_o      (sda_o),
      .sda_t      (sda_t),
      .own_addr   (own_addr),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .start_det  (start_det),
      .stop_det   (stop_det),
      .addr_match (addr_match),
      .rw         (rw),
      .busy       (busy)
   );

   int tests = 0;
   int fails = 0;

   // Event counters and observed-byte queue, written only by the monitors.
   int         start_cnt = 0, stop_cnt = 0, match_cnt = 0, rxv_cnt = 0, tmis = 0, hs_cnt = 0;
   logic [7:0] got_rx_q [$];
   logic [7:0] exp_rx_q [$];
   logic [7:0] exp_rd_q [$];

   // Read-data source: bytes in tx_mem are offered while auto_tx is set.
   logic [7:0] tx_mem [16];
   int         tx_n    = 0;
   bit         auto_tx = 1'b0;

   always @(negedge clk) begin
      if (start_det)  start_cnt++;
      if (stop_det)   stop_cnt++;
      if (addr_match) match_cnt++;
      if (rx_valid) begin
         rxv_cnt++;
         got_rx_q.push_back(rx_data);
      end
      if (scl_t !== scl_o || sda_t !== sda_o) tmis++;
   end

   always @(posedge clk) begin
      if (tx_valid && tx_ready) hs_cnt++;
   end

   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (auto_tx && hs_cnt < tx_n && hs_cnt < 16) begin
            tx_valid = 1'b1;
            tx_data  = tx_mem[hs_cnt];
         end else begin
            tx_valid = 1'b0;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_scl_high();
      int k = 0;
      while (scl_bus !== 1'b1 && k < 5000) begin
         wait_cyc(1);
         k++;
      end
      if (k >= 5000) begin
         tests++;
         fails++;
         $display("FAIL scl_release_timeout: got scl=%0b, expected 1 within 5000 cycles", scl_bus);
      end
   endtask

   task automatic i2c_start();
      sda_ctl = 1'b1;
      wait_cyc(15);
      scl_ctl = 1'b1;
      wait_scl_high();
      wait_cyc(20);
      sda_ctl = 1'b0;
      wait_cyc(20);
      scl_ctl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_cyc(10);
      sda_ctl = 1'b0;
      wait_cyc(10);
      scl_ctl = 1'b1;
      wait_scl_high();
      wait_cyc(20);
      sda_ctl = 1'b1;
      wait_cyc(20);
   endtask

   task automatic send_bit(input logic b, output logic s);
      wait_cyc(10);
      sda_ctl = b;
      wait_cyc(10);
      scl_ctl = 1'b1;
      wait_scl_high();
      wait_cyc(10);
      s = sda_bus;
      wait_cyc(10);
      scl_ctl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(d[i], s);
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         d[i] = s;
      end
   endtask

   task automatic read_and_score(input string name);
      logic [7:0] d;
      logic [7:0] e;
      read_byte(d);
      e = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 8'hxx;
      check(name, int'(d), int'(e));
   endtask

   typedef struct {
      logic [6:0] own;
      logic [7:0] addr_b;
      logic [7:0] data;
      bit         ack;
   } wr_vec_t;

   wr_vec_t vec [6];

   initial begin
      logic       ack, s;
      int         s_start, s_stop, s_match, s_rxv, s_hs, low;

      vec[0] = '{7'h50, 8'hA0, 8'h3C, 1'b1};
      vec[1] = '{7'h50, 8'hA4, 8'h55, 1'b0};
      vec[2] = '{7'h50, 8'hA0, 8'hC3, 1'b1};
      vec[3] = '{7'h2A, 8'h54, 8'h00, 1'b1};
      vec[4] = '{7'h7F, 8'hFE, 8'hFF, 1'b1};
      vec[5] = '{7'h01, 8'h04, 8'h81, 1'b0};

      rst      = 1'b1;
      scl_ctl  = 1'b1;
      sda_ctl  = 1'b1;
      own_addr = 7'h50;
      wait_cyc(4);
      check("rst_sda_o",    int'(sda_o),    1);
      check("rst_scl_o",    int'(scl_o),    1);
      check("rst_busy",     int'(busy),     0);
      check("rst_tx_ready", int'(tx_ready), 0);
      check("rst_rx_data",  int'(rx_data),  0);
      check("rst_rw",       int'(rw),       0);
      check("rst_rx_valid", int'(rx_valid), 0);
      rst = 1'b0;
      wait_cyc(20);

      // Write transactions from the vector table.
      for (int i = 0; i < 6; i++) begin
         own_addr = vec[i].own;
         s_start  = start_cnt;
         s_stop   = stop_cnt;
         s_match  = match_cnt;
         s_rxv    = rxv_cnt;
         i2c_start();
         send_byte(vec[i].addr_b, ack);
         check($sformatf("wr%0d_addr_ack", i), int'(ack), int'(vec[i].ack));
         check($sformatf("wr%0d_addr_match", i), match_cnt - s_match, int'(vec[i].ack));
         if (vec[i].ack) exp_rx_q.push_back(vec[i].data);
         send_byte(vec[i].data, ack);
         check($sformatf("wr%0d_data_ack", i), int'(ack), int'(vec[i].ack));
         i2c_stop();
         check($sformatf("wr%0d_start_det", i), start_cnt - s_start, 1);
         check($sformatf("wr%0d_stop_det", i), stop_cnt - s_stop, 1);
         check($sformatf("wr%0d_rx_valid_cnt", i), rxv_cnt - s_rxv, int'(vec[i].ack));
         check($sformatf("wr%0d_busy", i), int'(busy), 0);
         if (vec[i].ack) begin
            check($sformatf("wr%0d_rw", i), int'(rw), 0);
            check($sformatf("wr%0d_rx_data_port", i), int'(rx_data), int'(vec[i].data));
         end
         while (exp_rx_q.size() > 0 && got_rx_q.size() > 0)
            check($sformatf("wr%0d_rx_byte", i), int'(got_rx_q.pop_front()), int'(exp_rx_q.pop_front()));
         check($sformatf("wr%0d_rx_queue_left", i), exp_rx_q.size() + got_rx_q.size(), 0);
         exp_rx_q.delete();
         got_rx_q.delete();
         wait_cyc(20);
      end

      // Read with clock stretch: no data for 50 cycles, then 0x96.
      own_addr = 7'h50;
      auto_tx  = 1'b0;
      s_hs     = hs_cnt;
      tx_mem[tx_n] = 8'h96;
      tx_n++;
      i2c_start();
      send_byte(8'hA1, ack);
      check("st_addr_ack", int'(ack), 1);
      wait_cyc(15);
      check("st_tx_ready", int'(tx_ready), 1);
      low = 0;
      for (int k = 0; k < 50; k++) begin
         if (scl_o == 1'b0) low++;
         wait_cyc(1);
      end
      check("st_scl_low_cycles", low, 50);
      check("st_no_handshake_yet", hs_cnt - s_hs, 0);
      exp_rd_q.push_back(8'h96);
      auto_tx = 1'b1;
      read_and_score("st_read_byte");
      send_bit(1'b1, s);
      i2c_stop();
      auto_tx = 1'b0;
      check("st_handshakes", hs_cnt - s_hs, 1);
      check("st_busy", int'(busy), 0);
      wait_cyc(20);

      // Two-byte read: ACK after byte 1, NACK after byte 2.
      s_hs = hs_cnt;
      tx_mem[tx_n] = 8'h5A; tx_n++; exp_rd_q.push_back(8'h5A);
      tx_mem[tx_n] = 8'hC3; tx_n++; exp_rd_q.push_back(8'hC3);
      auto_tx = 1'b1;
      i2c_start();
      check("rd_busy_mid", int'(busy), 1);
      send_byte(8'hA1, ack);
      check("rd_addr_ack", int'(ack), 1);
      check("rd_rw", int'(rw), 1);
      read_and_score("rd_byte1");
      send_bit(1'b0, s);
      read_and_score("rd_byte2");
      send_bit(1'b1, s);
      wait_cyc(10);
      check("rd_sda_released", int'(sda_o), 1);
      check("rd_handshakes", hs_cnt - s_hs, 2);
      exp_rd_q.push_back(8'hFF);
      read_and_score("rd_ignore_byte");
      send_bit(1'b1, s);
      check("rd_ignore_tx_ready", int'(tx_ready), 0);
      check("rd_ignore_handshakes", hs_cnt - s_hs, 2);
      i2c_stop();
      auto_tx = 1'b0;
      wait_cyc(20);

      // Repeated START: write address, then read address.
      s_start = start_cnt;
      s_match = match_cnt;
      s_rxv   = rxv_cnt;
      s_hs    = hs_cnt;
      i2c_start();
      send_byte(8'hA0, ack);
      check("rs_wr_ack", int'(ack), 1);
      i2c_start();
      send_byte(8'hA1, ack);
      check("rs_rd_ack", int'(ack), 1);
      check("rs_rw", int'(rw), 1);
      wait_cyc(15);
      check("rs_tx_ready", int'(tx_ready), 1);
      check("rs_start_cnt", start_cnt - s_start, 2);
      check("rs_match_cnt", match_cnt - s_match, 2);
      check("rs_no_rx_valid", rxv_cnt - s_rxv, 0);
      tx_mem[tx_n] = 8'h11; tx_n++; exp_rd_q.push_back(8'h11);
      auto_tx = 1'b1;
      read_and_score("rs_read_byte");
      send_bit(1'b1, s);
      i2c_stop();
      auto_tx = 1'b0;
      check("rs_handshakes", hs_cnt - s_hs, 1);
      wait_cyc(20);

      // Glitch filter: 2-cycle SDA dip rejected, 8-cycle dip accepted.
      s_start = start_cnt;
      s_stop  = stop_cnt;
      sda_ctl = 1'b0;
      wait_cyc(2);
      sda_ctl = 1'b1;
      wait_cyc(30);
      check("gl_no_start", start_cnt - s_start, 0);
      check("gl_no_stop", stop_cnt - s_stop, 0);
      check("gl_busy", int'(busy), 0);
      sda_ctl = 1'b0;
      wait_cyc(8);
      check("gl_long_busy", int'(busy), 1);
      sda_ctl = 1'b1;
      wait_cyc(20);
      check("gl_long_start", start_cnt - s_start, 1);
      check("gl_long_stop", stop_cnt - s_stop, 1);

      // Reset while ACKing, then the rest of the transfer is ignored.
      s_match = match_cnt;
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(vec[0].addr_b[i], s);
      sda_ctl = 1'b1;
      wait_cyc(10);
      check("rs_sda_ack_low", int'(sda_o), 0);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      check("rst_mid_sda_o", int'(sda_o), 1);
      check("rst_mid_busy", int'(busy), 0);
      s_rxv  = rxv_cnt;
      s_stop = stop_cnt;
      send_bit(1'b1, s);
      send_byte(8'h77, ack);
      check("rst_mid_ignored_ack", int'(ack), 0);
      i2c_stop();
      check("rst_mid_no_rx", rxv_cnt - s_rxv, 0);
      check("rst_mid_match_once", match_cnt - s_match, 1);
      check("rst_mid_stop", stop_cnt - s_stop, 1);
      check("tristate_mirror", tmis, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
